dllp_tx_builder: RTL

Transmit-side DLLP builder for the PCIe data link layer. It accepts one DLLP request per handshake (type, VC, 24-bit payload) and encodes the type into the byte-0 encoding that `dllp_decoder` interprets. It appends the 16-bit DLLP CRC and serializes the resulting 6-byte DLLP onto a byte-wide valid/ready stream toward the framing/PHY mux. It sits opposite `dllp_decoder` on the link: everything this block emits must decode to the requested type.

---
 rtl/dllp_tx_builder_pkg.sv | 99 +++++++++
 rtl/dllp_tx_builder_crc16.sv | 48 ++++
 rtl/dllp_tx_builder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dllp_tx_builder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dllp_defines (package)
// Brief    : Shared DLLP definitions for the transmit builder and the decoder:
//            request type enumeration, byte-0 encodings, FC nibbles, CRC
//            constants and the type-to-byte-0 encode helper.
// Revision : 1.0 - initial release
// ============================================================================
package dllp_defines;

    typedef enum logic [4:0] {
        DLLP_ACK                    = 5'd0,
        DLLP_MRINIT                 = 5'd1,
        DLLP_DATA_LINK_FEATURE      = 5'd2,
        DLLP_NAK                    = 5'd3,
        DLLP_PM_ENTER_L1            = 5'd4,
        DLLP_PM_ENTER_L23           = 5'd5,
        DLLP_PM_ACTIVE_STATE_REQ_L1 = 5'd6,
        DLLP_PM_REQUEST_ACK         = 5'd7,
        DLLP_VENDOR_SPECIFIC        = 5'd8,
        DLLP_NOP                    = 5'd9,
        DLLP_INITFC1_P              = 5'd10,
        DLLP_INITFC1_NP             = 5'd11,
        DLLP_INITFC1_CPL            = 5'd12,
        DLLP_MRINITFC1              = 5'd13,
        DLLP_UPDATEFC_P             = 5'd14,
        DLLP_UPDATEFC_NP            = 5'd15,
        DLLP_UPDATEFC_CPL           = 5'd16,
        DLLP_MRUPDATEFC             = 5'd17,
        DLLP_INITFC2_P              = 5'd18,
        DLLP_INITFC2_NP             = 5'd19,
        DLLP_INITFC2_CPL            = 5'd20,
        DLLP_MRINITFC2              = 5'd21,
        DLLP_RESERVED               = 5'd22
    } dllp_type_t;

    localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
    localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;

    localparam logic [7:0] DLLP_ENC_ACK                    = 8'h00;
    localparam logic [7:0] DLLP_ENC_MRINIT                 = 8'h01;
    localparam logic [7:0] DLLP_ENC_DATA_LINK_FEATURE      = 8'h02;
    localparam logic [7:0] DLLP_ENC_NAK                    = 8'h10;
    localparam logic [7:0] DLLP_ENC_PM_ENTER_L1            = 8'h20;
    localparam logic [7:0] DLLP_ENC_PM_ENTER_L23           = 8'h21;
    localparam logic [7:0] DLLP_ENC_PM_ACTIVE_STATE_REQ_L1 = 8'h23;
    localparam logic [7:0] DLLP_ENC_PM_REQUEST_ACK         = 8'h24;
    localparam logic [7:0] DLLP_ENC_VENDOR_SPECIFIC        = 8'h30;
    localparam logic [7:0] DLLP_ENC_NOP                    = 8'h31;

    localparam logic [3:0] DLLP_FC_INITFC1_P   = 4'h4;
    localparam logic [3:0] DLLP_FC_INITFC1_NP  = 4'h5;
    localparam logic [3:0] DLLP_FC_INITFC1_CPL = 4'h6;
    localparam logic [3:0] DLLP_FC_MRINITFC1   = 4'h7;
    localparam logic [3:0] DLLP_FC_UPDATEFC_P  = 4'h8;
    localparam logic [3:0] DLLP_FC_UPDATEFC_NP = 4'h9;
    localparam logic [3:0] DLLP_FC_UPDATEFC_CPL= 4'hA;
    localparam logic [3:0] DLLP_FC_MRUPDATEFC  = 4'hB;
    localparam logic [3:0] DLLP_FC_INITFC2_P   = 4'hC;
    localparam logic [3:0] DLLP_FC_INITFC2_NP  = 4'hD;
    localparam logic [3:0] DLLP_FC_INITFC2_CPL = 4'hE;
    localparam logic [3:0] DLLP_FC_MRINITFC2   = 4'hF;

    // Returns {legal, byte0}; anything not listed (including RESERVED) is illegal.
    function automatic logic [8:0] dllp_encode(input dllp_type_t dllp_type,
                                               input logic [2:0] vc);
        logic [8:0] enc;
        enc = 9'h000;
        case (dllp_type)
            DLLP_ACK:                    enc = {1'b1, DLLP_ENC_ACK};
            DLLP_MRINIT:                 enc = {1'b1, DLLP_ENC_MRINIT};
            DLLP_DATA_LINK_FEATURE:      enc = {1'b1, DLLP_ENC_DATA_LINK_FEATURE};
            DLLP_NAK:                    enc = {1'b1, DLLP_ENC_NAK};
            DLLP_PM_ENTER_L1:            enc = {1'b1, DLLP_ENC_PM_ENTER_L1};
            DLLP_PM_ENTER_L23:           enc = {1'b1, DLLP_ENC_PM_ENTER_L23};
            DLLP_PM_ACTIVE_STATE_REQ_L1: enc = {1'b1, DLLP_ENC_PM_ACTIVE_STATE_REQ_L1};
            DLLP_PM_REQUEST_ACK:         enc = {1'b1, DLLP_ENC_PM_REQUEST_ACK};
            DLLP_VENDOR_SPECIFIC:        enc = {1'b1, DLLP_ENC_VENDOR_SPECIFIC};
            DLLP_NOP:                    enc = {1'b1, DLLP_ENC_NOP};
            DLLP_INITFC1_P:              enc = {1'b1, DLLP_FC_INITFC1_P,    1'b0, vc};
            DLLP_INITFC1_NP:             enc = {1'b1, DLLP_FC_INITFC1_NP,   1'b0, vc};
            DLLP_INITFC1_CPL:            enc = {1'b1, DLLP_FC_INITFC1_CPL,  1'b0, vc};
            DLLP_MRINITFC1:              enc = {1'b1, DLLP_FC_MRINITFC1,    1'b0, vc};
            DLLP_UPDATEFC_P:             enc = {1'b1, DLLP_FC_UPDATEFC_P,   1'b0, vc};
            DLLP_UPDATEFC_NP:            enc = {1'b1, DLLP_FC_UPDATEFC_NP,  1'b0, vc};
            DLLP_UPDATEFC_CPL:           enc = {1'b1, DLLP_FC_UPDATEFC_CPL, 1'b0, vc};
            DLLP_MRUPDATEFC:             enc = {1'b1, DLLP_FC_MRUPDATEFC,   1'b0, vc};
            DLLP_INITFC2_P:              enc = {1'b1, DLLP_FC_INITFC2_P,    1'b0, vc};
            DLLP_INITFC2_NP:             enc = {1'b1, DLLP_FC_INITFC2_NP,   1'b0, vc};
            DLLP_INITFC2_CPL:            enc = {1'b1, DLLP_FC_INITFC2_CPL,  1'b0, vc};
            DLLP_MRINITFC2:              enc = {1'b1, DLLP_FC_MRINITFC2,    1'b0, vc};
            default:                     enc = 9'h000;
        endcase
        return enc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dllp_tx_builder_crc16.sv
`default_nettype none
// ============================================================================
// Module   : dllp_crc16
// Brief    : Combinational DLLP CRC-16 over bytes 0..3. Bytes enter in order,
//            each byte LSB first; the remainder is inverted and each half is
//            bit-reversed so o_crc[15:8] is byte 4 and o_crc[7:0] is byte 5.
// Revision : 1.0 - initial release
// ============================================================================
module dllp_crc16
    import dllp_defines::*;
(
    input  logic [31:0] i_data,
    output logic [15:0] o_crc
);

    logic [31:0] w_msg;
    logic [31:0] w_shift;
    logic [15:0] w_lfsr;
    logic [15:0] w_inv;

    // Reorder bits into transmission order: byte 0 first, bit 0 of each byte first.
    for (genvar k = 0; k < 4; k++) begin : g_byte
        for (genvar j = 0; j < 8; j++) begin : g_bit
            assign w_msg[31 - 8*k - j] = i_data[24 - 8*k + j];
        end
    end

    // Unrolled serial LFSR across all 32 message bits.
    always_comb begin
        w_lfsr  = DLLP_CRC_SEED;
        w_shift = w_msg;
        for (int n = 0; n < 32; n++) begin
            w_lfsr  = {w_lfsr[14:0], 1'b0} ^ ((w_lfsr[15] ^ w_shift[31]) ? DLLP_CRC_POLY : 16'h0000);
            w_shift = {w_shift[30:0], 1'b0};
        end
    end

    assign w_inv = ~w_lfsr;

    // Remainder bit 15 lands in byte 4 bit 0, remainder bit 7 in byte 5 bit 0.
    for (genvar i = 0; i < 8; i++) begin : g_map
        assign o_crc[8 + i] = w_inv[15 - i];
        assign o_crc[i]     = w_inv[7 - i];
    end

endmodule

`default_nettype wire

// File: rtl/dllp_tx_builder.sv
`default_nettype none
// ============================================================================
// Module   : dllp_tx_builder
// Brief    : Accepts DLLP requests, encodes byte 0, appends the CRC-16 and
//            serializes the 6-byte DLLP onto a byte-wide valid/ready stream.
//            Optional macro DLLP_TX_ERR_INJ_EN adds err_inj, which flips the
//            CRC LSB (byte 5 bit 0) of the DLLP accepted in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dllp_tx_builder
    import dllp_defines::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  dllp_type_t       req_type,
    input  logic [2:0]       req_vc,
    input  logic [23:0]      req_payload,
`ifdef DLLP_TX_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic             bad_req,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_SEND   = 1'b1;
    localparam logic [2:0] c_LAST_BEAT = 3'd5;

    logic [0:0]       r_state;
    logic [2:0]       r_beat;
    logic [47:0]      r_frame;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_tx_sop;
    logic             r_tx_eop;
    logic             r_bad_req;
    logic [CNT_W-1:0] r_sent_cnt;

    logic [8:0]       w_enc;
    logic             w_legal;
    logic [15:0]      w_crc;
    logic [15:0]      w_crc_tx;
    logic [47:0]      w_frame;
    logic             w_done;
    logic             w_accept;

    assign w_enc   = dllp_encode(req_type, req_vc);
    assign w_legal = w_enc[8];

    dllp_crc16 u_crc (
        .i_data (w_enc[7:0] & {8{1'b1}} ? {w_enc[7:0], req_payload} : {w_enc[7:0], req_payload}),
        .o_crc  (w_crc)
    );

`ifdef DLLP_TX_ERR_INJ_EN
    assign w_crc_tx = w_crc ^ {15'd0, err_inj};
`else
    assign w_crc_tx = w_crc;
`endif

    assign w_frame = {w_enc[7:0], req_payload, w_crc_tx};

    // Last beat leaving this cycle frees the slot for a same-cycle request.
    assign w_done    = (r_state == c_ST_SEND) && (r_beat == c_LAST_BEAT) && tx_ready;
    assign req_ready = !rst && ((r_state == c_ST_IDLE) || w_done);
    assign w_accept  = req_valid && req_ready;

    // Control FSM, byte shifter and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_beat     <= 3'd0;
            r_frame    <= 48'd0;
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
            r_bad_req  <= 1'b0;
            r_sent_cnt <= '0;
        end else begin
            r_bad_req <= w_accept && !w_legal;
            if (w_done) begin
                r_sent_cnt <= r_sent_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_accept && w_legal) begin
                r_state    <= c_ST_SEND;
                r_beat     <= 3'd0;
                r_frame    <= {w_frame[39:0], 8'h00};
                r_tx_data  <= w_frame[47:40];
                r_tx_valid <= 1'b1;
                r_tx_sop   <= 1'b1;
                r_tx_eop   <= 1'b0;
            end else if (w_done) begin
                r_state    <= c_ST_IDLE;
                r_beat     <= 3'd0;
                r_tx_data  <= 8'd0;
                r_tx_valid <= 1'b0;
                r_tx_sop   <= 1'b0;
                r_tx_eop   <= 1'b0;
            end else if ((r_state == c_ST_SEND) && tx_ready) begin
                r_beat     <= r_beat + 3'd1;
                r_frame    <= {r_frame[39:0], 8'h00};
                r_tx_data  <= r_frame[47:40];
                r_tx_sop   <= 1'b0;
                r_tx_eop   <= (r_beat == 3'd4);
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_sop   = r_tx_sop;
    assign tx_eop   = r_tx_eop;
    assign bad_req  = r_bad_req;
    assign sent_cnt = r_sent_cnt;

endmodule

`default_nettype wire
